// File: rtl/sim_end_mon_pkg.sv
// ----------------------------------------------------------------------------
// sim_end_mon_pkg
// Shared types and constants for the simulation-termination monitor.
//   state_e      : monitor FSM state encoding (IDLE, RUN, DRAIN, DONE), 2 bits
//   TimeoutCode  : status word captured when the watchdog terminates a run
// ----------------------------------------------------------------------------
package sim_end_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [31:0] TimeoutCode = 32'hFFFF_FFFF;

endpackage

// File: rtl/sim_end_mon_port.sv
// ----------------------------------------------------------------------------
// sim_end_mon_port
// Combinational snoop of one memory write port. Flags a write to the
// end-of-sim byte address and presents the write data zero-extended to 32 bits.
// Ports:
//   req_i    in  1          port request
//   write_i  in  1          write qualifier
//   addr_i   in  WordAw     word address
//   wdata_i  in  DataWidth  write data
//   hit_o    out 1          write to EndAddr this cycle
//   data_o   out 32         wdata_i zero-extended
// ----------------------------------------------------------------------------
module sim_end_mon_port
   import sim_end_mon_pkg::*;
#(
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          WordAw    = 16,
   parameter int unsigned          DataWidth = 32,
   parameter logic [AddrWidth-1:0] MemBase   = 32'h1000_0000,
   parameter logic [AddrWidth-1:0] EndAddr   = 32'h1000_7ff8
) (
   input  logic                 req_i,
   input  logic                 write_i,
   input  logic [WordAw-1:0]    addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   output logic                 hit_o,
   output logic [31:0]          data_o
);

   logic [AddrWidth-1:0] byte_off;
   logic [AddrWidth-1:0] byte_addr;

   // Word address to byte offset; the sum deliberately wraps in AddrWidth bits.
   assign byte_off  = AddrWidth'({addr_i, 2'b00});
   assign byte_addr = MemBase + byte_off;

   assign hit_o  = req_i & write_i & (byte_addr == EndAddr);
   assign data_o = 32'(wdata_i);

endmodule

// File: rtl/sim_end_mon.sv
// ----------------------------------------------------------------------------
// sim_end_mon
// Simulation-termination monitor. Snoops NumPorts memory write ports for a
// write to EndAddr, captures the written status word, waits DrainCycles so
// console output can flush, then raises a sticky end_o. An optional RUN-state
// watchdog (TimeoutCycles != 0) ends hung runs with TimeoutCode.
// Optional feature macro: SIM_END_MON_DISPLAY_EN -- when defined, prints the
// result and calls $finish on DONE entry (simulation only).
// Ports:
//   clk_i      in  1                     clock
//   rst_ni     in  1                     asynchronous active-low reset
//   enable_i   in  1                     arms the monitor
//   req_i      in  NumPorts              per-port request
//   write_i    in  NumPorts              per-port write qualifier
//   addr_i     in  NumPorts x WordAw     per-port word address
//   wdata_i    in  NumPorts x DataWidth  per-port write data
//   end_o      out 1                     sticky end-of-simulation
//   pass_o     out 1                     captured code == PassCode, no timeout
//   timeout_o  out 1                     sticky watchdog fired
//   code_o     out 32                    captured status word
//   state_o    out 2                     current FSM state
// ----------------------------------------------------------------------------
module sim_end_mon
   import sim_end_mon_pkg::*;
#(
   parameter int unsigned          NumPorts      = 2,
   parameter int unsigned          AddrWidth     = 32,
   parameter int unsigned          WordAw        = 16,
   parameter int unsigned          DataWidth     = 32,
   parameter logic [AddrWidth-1:0] MemBase       = 32'h1000_0000,
   parameter logic [AddrWidth-1:0] EndAddr       = 32'h1000_7ff8,
   parameter logic [31:0]          PassCode      = 32'h0,
   parameter int unsigned          DrainCycles   = 16,
   parameter int unsigned          TimeoutCycles = 0
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                enable_i,
   input  logic [NumPorts-1:0]                 req_i,
   input  logic [NumPorts-1:0]                 write_i,
   input  logic [NumPorts-1:0][WordAw-1:0]     addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
   output logic                                end_o,
   output logic                                pass_o,
   output logic                                timeout_o,
   output logic [31:0]                         code_o,
   output logic [1:0]                          state_o
);

   localparam logic        WdEn      = (TimeoutCycles != 0);
   localparam logic [31:0] WdLast    = WdEn ? 32'(TimeoutCycles - 1) : 32'd0;
   localparam logic [31:0] DrainLast = 32'(DrainCycles);

   logic [NumPorts-1:0]       hit;
   logic [NumPorts-1:0][31:0] port_data;
   logic                      any_hit;
   logic [31:0]               hit_data;

   state_e      state_q;
   logic [31:0] run_cnt_q;
   logic [31:0] drain_cnt_q;
   logic        end_q;
   logic        pass_q;
   logic        timeout_q;
   logic [31:0] code_q;

   for (genvar p = 0; p < NumPorts; p++) begin : g_port
      sim_end_mon_port #(
         .AddrWidth (AddrWidth),
         .WordAw    (WordAw),
         .DataWidth (DataWidth),
         .MemBase   (MemBase),
         .EndAddr   (EndAddr)
      ) u_port (
         .req_i   (req_i[p]),
         .write_i (write_i[p]),
         .addr_i  (addr_i[p]),
         .wdata_i (wdata_i[p]),
         .hit_o   (hit[p]),
         .data_o  (port_data[p])
      );
   end

   // Scan from the top down so the lowest-index hitting port wins.
   always_comb begin
      any_hit  = 1'b0;
      hit_data = '0;
      for (int p = NumPorts - 1; p >= 0; p--) begin
         if (hit[p]) begin
            any_hit  = 1'b1;
            hit_data = port_data[p];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         run_cnt_q   <= '0;
         drain_cnt_q <= '0;
         end_q       <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         code_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable_i) begin
                  state_q   <= RUN;
                  run_cnt_q <= '0;
               end
            end
            RUN: begin
               // A real status write takes precedence over the watchdog.
               if (any_hit) begin
                  state_q     <= DRAIN;
                  code_q      <= hit_data;
                  drain_cnt_q <= '0;
               end else if (WdEn && (run_cnt_q == WdLast)) begin
                  state_q     <= DRAIN;
                  code_q      <= TimeoutCode;
                  timeout_q   <= 1'b1;
                  drain_cnt_q <= '0;
               end else if (!enable_i) begin
                  state_q   <= IDLE;
                  run_cnt_q <= '0;
               end else if (run_cnt_q != '1) begin
                  run_cnt_q <= run_cnt_q + 32'd1;
               end
            end
            DRAIN: begin
               // Counter visits 0..DrainCycles; DONE is entered DrainCycles+1
               // edges after the terminating write.
               if (drain_cnt_q == DrainLast) begin
                  state_q <= DONE;
                  end_q   <= 1'b1;
                  pass_q  <= (code_q == PassCode) && !timeout_q;
`ifdef SIM_END_MON_DISPLAY_EN
                  $display("sim_end_mon: code=%08h pass=%0d timeout=%0d",
                           code_q, (code_q == PassCode) && !timeout_q, timeout_q);
                  $finish;
`endif
               end else begin
                  drain_cnt_q <= drain_cnt_q + 32'd1;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign end_o     = end_q;
   assign pass_o    = pass_q;
   assign timeout_o = timeout_q;
   assign code_o    = code_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_sim_end_mon.sv
// ----------------------------------------------------------------------------
// tb_sim_end_mon
// Directed bench for sim_end_mon. Two instances share the stimulus: the default
// configuration (DrainCycles=16, no watchdog) and a watchdog configuration
// (TimeoutCycles=100, DrainCycles=2).
// ----------------------------------------------------------------------------
module tb_sim_end_mon;

   localparam logic [15:0] EndWord = 16'h1FFE;  // (0x1000_7ff8 - 0x1000_0000) >> 2

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              enable_i;
   logic [1:0]        req_i;
   logic [1:0]        write_i;
   logic [1:0][15:0]  addr_i;
   logic [1:0][31:0]  wdata_i;

   logic        end_o,  pass_o,  timeout_o;
   logic [31:0] code_o;
   logic [1:0]  state_o;
   logic        wd_end, wd_pass, wd_timeout;
   logic [31:0] wd_code;
   logic [1:0]  wd_state;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   sim_end_mon dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .enable_i  (enable_i),
      .req_i     (req_i),
      .write_i   (write_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .end_o     (end_o),
      .pass_o    (pass_o),
      .timeout_o (timeout_o),
      .code_o    (code_o),
      .state_o   (state_o)
   );

   sim_end_mon #(
      .TimeoutCycles (100),
      .DrainCycles   (2)
   ) dut_wd (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .enable_i  (enable_i),
      .req_i     (req_i),
      .write_i   (write_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .end_o     (wd_end),
      .pass_o    (wd_pass),
      .timeout_o (wd_timeout),
      .code_o    (wd_code),
      .state_o   (wd_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic idle_ports();
      req_i   = '0;
      write_i = '0;
      addr_i  = '0;
      wdata_i = '0;
   endtask

   task automatic do_reset();
      idle_ports();
      enable_i = 1'b0;
      rst_ni   = 1'b0;
      step(2);
      rst_ni = 1'b1;
      step(1);
   endtask

   task automatic wr(input int p, input logic [15:0] a, input logic [31:0] d);
      req_i[p]   = 1'b1;
      write_i[p] = 1'b1;
      addr_i[p]  = a;
      wdata_i[p] = d;
   endtask

   initial begin
      idle_ports();
      enable_i = 1'b0;
      rst_ni   = 1'b0;
      step(2);
      // Reset state
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_end",   32'(end_o), 32'd0);
      chk("rst_pass",  32'(pass_o), 32'd0);
      chk("rst_tmo",   32'(timeout_o), 32'd0);
      chk("rst_code",  code_o, 32'd0);
      rst_ni = 1'b1;
      step(1);

      // Test 1: port0 writes pass code, end_o 17 edges after the hit
      enable_i = 1'b1;
      step(1);
      chk("t1_run", 32'(state_o), 32'd1);
      wr(0, EndWord, 32'h0);
      step(1);
      idle_ports();
      chk("t1_drain", 32'(state_o), 32'd2);
      chk("t1_code",  code_o, 32'h0);
      step(16);
      chk("t1_end_early", 32'(end_o), 32'd0);
      step(1);
      chk("t1_end",  32'(end_o), 32'd1);
      chk("t1_pass", 32'(pass_o), 32'd1);
      chk("t1_done", 32'(state_o), 32'd3);
      enable_i = 1'b0;
      step(3);
      chk("t1_sticky_end",   32'(end_o), 32'd1);
      chk("t1_sticky_state", 32'(state_o), 32'd3);

      // Test 2: port1 writes a fail code
      do_reset();
      enable_i = 1'b1;
      step(1);
      wr(1, EndWord, 32'h0000_00AB);
      step(1);
      idle_ports();
      step(17);
      chk("t2_end",  32'(end_o), 32'd1);
      chk("t2_code", code_o, 32'h0000_00AB);
      chk("t2_pass", 32'(pass_o), 32'd0);
      chk("t2_tmo",  32'(timeout_o), 32'd0);

      // Test 3: simultaneous hits, lowest port wins; later hit ignored
      do_reset();
      enable_i = 1'b1;
      step(1);
      wr(0, EndWord, 32'd5);
      wr(1, EndWord, 32'd7);
      step(1);
      idle_ports();
      chk("t3_code_prio", code_o, 32'd5);
      wr(1, EndWord, 32'd9);
      step(1);
      idle_ports();
      chk("t3_code_hold", code_o, 32'd5);
      chk("t3_drain",     32'(state_o), 32'd2);
      step(16);
      chk("t3_end",  32'(end_o), 32'd1);
      chk("t3_pass", 32'(pass_o), 32'd0);

      // Test 4: watchdog fires on RUN cycle 100; default instance never times out
      do_reset();
      enable_i = 1'b1;
      step(1);
      step(99);
      chk("t4_wd_still_run", 32'(wd_state), 32'd1);
      step(1);
      chk("t4_wd_drain", 32'(wd_state), 32'd2);
      chk("t4_wd_code",  wd_code, 32'hFFFF_FFFF);
      chk("t4_wd_tmo",   32'(wd_timeout), 32'd1);
      step(2);
      chk("t4_wd_end_early", 32'(wd_end), 32'd0);
      step(1);
      chk("t4_wd_end",  32'(wd_end), 32'd1);
      chk("t4_wd_pass", 32'(wd_pass), 32'd0);
      chk("t4_nowd_run", 32'(state_o), 32'd1);
      chk("t4_nowd_tmo", 32'(timeout_o), 32'd0);
      // enable deassert: RUN returns to IDLE, DONE unaffected
      enable_i = 1'b0;
      step(1);
      chk("t4_disable_idle", 32'(state_o), 32'd0);
      chk("t4_disable_done", 32'(wd_state), 32'd3);

      // Test 5: ignored hits, then async reset in DRAIN
      do_reset();
      wr(0, EndWord, 32'h0);
      step(1);
      chk("t5_idle_hit", 32'(state_o), 32'd0);
      idle_ports();
      enable_i = 1'b1;
      step(1);
      wr(0, EndWord + 16'd1, 32'h0);
      step(1);
      chk("t5_wrong_addr", 32'(state_o), 32'd1);
      idle_ports();
      req_i[1]  = 1'b1;
      addr_i[1] = EndWord;
      step(1);
      chk("t5_read_only", 32'(state_o), 32'd1);
      idle_ports();
      wr(1, EndWord, 32'h1234_5678);
      step(1);
      idle_ports();
      chk("t5_drain", 32'(state_o), 32'd2);
      chk("t5_code",  code_o, 32'h1234_5678);
      step(3);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t5_arst_state", 32'(state_o), 32'd0);
      chk("t5_arst_code",  code_o, 32'd0);
      chk("t5_arst_end",   32'(end_o), 32'd0);
      step(1);
      rst_ni = 1'b1;
      step(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
